// File: rtl/dmem_responder_if.sv
// Data-memory access bus between the pipeline memory stage and the
// multi-cycle data-memory responder.
interface dmem_responder_if;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, wr, addr, wdata, wstrb,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  req, wr, addr, wdata, wstrb,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time,
// completes it LATENCY cycles later with a one-cycle ready pulse, and
// raises busy so the hazard unit stalls the pipeline meanwhile.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [1:0]        stateNext;
    logic [3:0]        count;

    logic              wrQ;
    logic [ADDR_W+1:0] addrQ;
    logic [31:0]       wdataQ;
    logic [3:0]        wstrbQ;

    logic [31:0]       mem [2**ADDR_W];

    logic              accept;
    logic              enterDone;
    logic              accWr;
    logic [ADDR_W+1:0] accAddr;
    logic [31:0]       accWdata;
    logic [3:0]        accWstrb;
    logic [ADDR_W-1:0] wordIdx;
    logic              misaligned;
    logic              memWrite;
    logic              unusedAddrHi;

    // Upper address bits only alias onto the array, so they are dropped.
    assign unusedAddrHi = ^bus.addr[31:ADDR_W+2];

    assign accept = (state == IDLE) && bus.req;

    // With LATENCY=1 the access completes on the accepting edge itself, so
    // the request fields come straight from the bus instead of the latches.
    assign enterDone = (accept && (LATENCY == 1)) ||
                       ((state == WAIT) && (count == 4'd1));

    assign accWr    = (state == IDLE) ? bus.wr                 : wrQ;
    assign accAddr  = (state == IDLE) ? bus.addr[ADDR_W+1:0]   : addrQ;
    assign accWdata = (state == IDLE) ? bus.wdata              : wdataQ;
    assign accWstrb = (state == IDLE) ? bus.wstrb              : wstrbQ;

    assign wordIdx    = accAddr[ADDR_W+1:2];
    assign misaligned = (accAddr[1:0] != 2'b00);

    // Reset gating keeps a LATENCY=1 request seen during reset from storing.
    assign memWrite = enterDone && accWr && !misaligned && rst;

    assign bus.busy = ((state == IDLE) && bus.req) || (state == WAIT);

    // Next-state selection; req is only looked at while idle.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.req) stateNext = (LATENCY == 1) ? DONE : WAIT;
            WAIT:    if (count == 4'd1) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Control state, latency counter and latched request fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= 4'd0;
            wrQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= 32'd0;
            wstrbQ <= 4'd0;
        end else begin
            state <= stateNext;
            if (accept) begin
                count  <= LOAD_CNT;
                wrQ    <= bus.wr;
                addrQ  <= bus.addr[ADDR_W+1:0];
                wdataQ <= bus.wdata;
                wstrbQ <= bus.wstrb;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
        end
    end

    // Completion outputs: ready/err pulse in DONE, rdata holds afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= 32'd0;
        end else if (enterDone) begin
            bus.ready <= 1'b1;
            bus.err   <= misaligned;
            if (misaligned || accWr) begin
                bus.rdata <= 32'd0;
            end else begin
                bus.rdata <= mem[wordIdx];
            end
        end else begin
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
        end
    end

    // Byte-lane store into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (accWstrb[lane]) begin
                    mem[wordIdx][8*lane +: 8] <= accWdata[8*lane +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance carries most
// traffic, a LATENCY=1 instance covers the single-cycle build.
module tb_dmem_responder;
    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qA[$];
    exp_t qB[$];

    always #5 clk = ~clk;

    // Cycle index; a value driven just after edge k lives in cycle k.
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if busA ();
    dmem_responder_if busB ();

    dmem_responder #(.ADDR_W(8), .LATENCY(2)) dutA (.clk(clk), .rst(rst), .bus(busA.slave));
    dmem_responder #(.ADDR_W(8), .LATENCY(1)) dutB (.clk(clk), .rst(rst), .bus(busB.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (busA.ready === 1'b1) begin
            if (qA.size() == 0) begin
                check("A_unexpected_ready", 32'(busA.ready), 32'd0);
            end else begin
                e = qA.pop_front();
                check("A_ready_cycle", 32'(cyc), 32'(e.cyc));
                check("A_rdata", busA.rdata, e.rdata);
                check("A_err", 32'(busA.err), 32'(e.err));
                check("A_busy_in_done", 32'(busA.busy), 32'd0);
            end
        end
        if (busB.ready === 1'b1) begin
            if (qB.size() == 0) begin
                check("B_unexpected_ready", 32'(busB.ready), 32'd0);
            end else begin
                e = qB.pop_front();
                check("B_ready_cycle", 32'(cyc), 32'(e.cyc));
                check("B_rdata", busB.rdata, e.rdata);
                check("B_err", 32'(busB.err), 32'(e.err));
                check("B_busy_in_done", 32'(busB.busy), 32'd0);
            end
        end
    end

    // One access: drive in the current cycle, check busy until DONE,
    // return in the following IDLE cycle.
    task automatic doAccess(input bit sel, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            input logic [31:0] expRd, input bit expErr);
        int   lat;
        exp_t e;
        lat = sel ? 1 : 2;
        e.cyc = cyc + lat;
        e.rdata = expRd;
        e.err = expErr;
        if (sel) begin
            busB.req = 1'b1; busB.wr = wr; busB.addr = addr; busB.wdata = wdata; busB.wstrb = wstrb;
            qB.push_back(e);
        end else begin
            busA.req = 1'b1; busA.wr = wr; busA.addr = addr; busA.wdata = wdata; busA.wstrb = wstrb;
            qA.push_back(e);
        end
        @(negedge clk);
        check(sel ? "B_busy_accept" : "A_busy_accept", 32'(sel ? busB.busy : busA.busy), 32'd1);
        @(posedge clk); #1;
        if (sel) busB.req = 1'b0; else busA.req = 1'b0;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check(sel ? "B_busy_wait" : "A_busy_wait", 32'(sel ? busB.busy : busA.busy), 32'd1);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        busA.req = 1'b0; busA.wr = 1'b0; busA.addr = 32'd0; busA.wdata = 32'd0; busA.wstrb = 4'd0;
        busB.req = 1'b0; busB.wr = 1'b0; busB.addr = 32'd0; busB.wdata = 32'd0; busB.wstrb = 4'd0;

        // Reset state, and busy tracking req while held in reset
        @(negedge clk);
        check("rst_A_ready", 32'(busA.ready), 32'd0);
        check("rst_A_err", 32'(busA.err), 32'd0);
        check("rst_A_rdata", busA.rdata, 32'd0);
        check("rst_A_busy_req0", 32'(busA.busy), 32'd0);
        check("rst_B_rdata", busB.rdata, 32'd0);
        busA.req = 1'b1; busB.req = 1'b1;
        #1;
        check("rst_A_busy_req1", 32'(busA.busy), 32'd1);
        check("rst_B_busy_req1", 32'(busB.busy), 32'd1);
        @(posedge clk); #1;
        busA.req = 1'b0; busB.req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Full store, load back, partial store, misaligned load
        doAccess(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0);
        doAccess(0, 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0);
        doAccess(0, 1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 0);
        doAccess(0, 0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEAA, 0);
        doAccess(0, 0, 32'h13, 32'h0, 4'b0000, 32'h0, 1);
        doAccess(0, 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 0);

        // Aliasing: 0x400 is word 256, which wraps to word 0
        doAccess(0, 1, 32'h400, 32'h12345678, 4'b1111, 32'h0, 0);
        doAccess(0, 0, 32'h000, 32'h0, 4'b0000, 32'h12345678, 0);

        // Empty strobe, misaligned store, sparse strobe
        doAccess(0, 1, 32'h24, 32'hCAFEF00D, 4'b1111, 32'h0, 0);
        doAccess(0, 1, 32'h24, 32'hFFFFFFFF, 4'b0000, 32'h0, 0);
        doAccess(0, 0, 32'h24, 32'h0, 4'b0000, 32'hCAFEF00D, 0);
        doAccess(0, 1, 32'h26, 32'h55555555, 4'b1111, 32'h0, 1);
        doAccess(0, 0, 32'h24, 32'h0, 4'b0000, 32'hCAFEF00D, 0);
        doAccess(0, 1, 32'h24, 32'h11223344, 4'b1010, 32'h0, 0);
        doAccess(0, 0, 32'h24, 32'h0, 4'b0000, 32'h11FE330D, 0);

        // Reset in the middle of a store discards it
        doAccess(0, 1, 32'h20, 32'h11111111, 4'b1111, 32'h0, 0);
        busA.req = 1'b1; busA.wr = 1'b1; busA.addr = 32'h20; busA.wdata = 32'h99999999; busA.wstrb = 4'b1111;
        @(posedge clk); #1;
        busA.req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(busA.ready), 32'd0);
        check("abort_err", 32'(busA.err), 32'd0);
        check("abort_rdata", busA.rdata, 32'd0);
        check("abort_busy", 32'(busA.busy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        doAccess(0, 0, 32'h20, 32'h0, 4'b0000, 32'h11111111, 0);

        // Back-to-back loads with req held high
        begin
            exp_t e;
            int   t0;
            t0 = cyc;
            busA.req = 1'b1; busA.wr = 1'b0; busA.addr = 32'h24; busA.wstrb = 4'b0000;
            for (int n = 0; n < 3; n++) begin
                e.cyc = t0 + 2 + 3 * n;
                e.rdata = 32'h11FE330D;
                e.err = 1'b0;
                qA.push_back(e);
            end
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                check("stream_busy", 32'(busA.busy), ((k % 3) == 2) ? 32'd0 : 32'd1);
                @(posedge clk); #1;
            end
            busA.req = 1'b0;
            @(posedge clk); #1;
        end

        // Single-cycle build: ready one edge after acceptance
        doAccess(1, 1, 32'h30, 32'hA5A5A5A5, 4'b1111, 32'h0, 0);
        doAccess(1, 0, 32'h30, 32'h0, 4'b0000, 32'hA5A5A5A5, 0);
        doAccess(1, 0, 32'h31, 32'h0, 4'b0000, 32'h0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("A_queue_drained", 32'(qA.size()), 32'd0);
        check("B_queue_drained", 32'(qB.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
